// File: rtl/bakraid_cen_gate.sv
// Pause / single-step gate for the CEN/CENB clock-enable fabric.
// Domains freeze only at a balanced point: a passed CEN must see its CENB first.
module bakraid_cen_gate #(
  parameter int N     = 4,
  parameter int STEPW = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N-1:0]     CEN_IN,
  input  logic [N-1:0]     CENB_IN,
  input  logic             PAUSE_REQ,
  input  logic             STEP_REQ,
  input  logic [STEPW-1:0] STEP_CNT,
  output logic [N-1:0]     CEN_OUT,
  output logic [N-1:0]     CENB_OUT,
  output logic             PAUSED,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_PAUSED,
    S_STEP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [N-1:0]     gate_open;
  logic [N-1:0]     open_nx;
  logic [N-1:0]     phase;
  logic [N-1:0]     phase_nx;
  logic [N-1:0]     drain_open;
  logic [STEPW-1:0] cnt;
  logic [STEPW-1:0] cnt_nx;

  assign CEN_OUT  = CEN_IN & gate_open;
  assign CENB_OUT = CENB_IN & gate_open;

  // phase = 1 while a CEN is outstanding; CEN+CENB together is a full cycle
  always_comb begin
    phase_nx = phase;
    for (int i = 0; i < N; i++) begin
      if (CEN_IN[i])
        phase_nx[i] = ~CENB_IN[i];
      else if (CENB_IN[i])
        phase_nx[i] = 1'b0;
    end
  end

  assign drain_open = gate_open & phase_nx;

  always_comb begin
    state_nx = state;
    open_nx  = gate_open;
    cnt_nx   = cnt;
    unique case (state)
      S_RUN: begin
        open_nx = '1;
        if (PAUSE_REQ)
          state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!PAUSE_REQ) begin
          state_nx = S_RUN;
          open_nx  = '1;
        end else begin
          open_nx = drain_open;
          if (drain_open == '0)
            state_nx = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (!PAUSE_REQ) begin
          state_nx = S_RUN;
          open_nx  = '1;
        end else if (STEP_REQ && STEP_CNT != '0) begin
          state_nx = S_STEP;
          open_nx  = '1;
          cnt_nx   = STEP_CNT;
        end
      end
      S_STEP: begin
        if (!PAUSE_REQ) begin
          state_nx = S_RUN;
          open_nx  = '1;
          cnt_nx   = '0;
        end else if (CEN_IN[0] && cnt != '0) begin
          cnt_nx = cnt - STEPW'(1);
          // last released CEN: drain lets its CENB through
          if (cnt == STEPW'(1))
            state_nx = S_DRAIN;
        end
      end
      default: begin
        state_nx = S_RUN;
        open_nx  = '1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_RUN;
      gate_open <= '1;
      phase     <= '0;
      cnt       <= '0;
      PAUSED    <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_nx;
      gate_open <= open_nx;
      phase     <= phase_nx;
      cnt       <= cnt_nx;
      PAUSED    <= (state_nx == S_PAUSED);
      BUSY      <= (state_nx == S_DRAIN) || (state_nx == S_STEP);
    end
  end

endmodule

// File: tb/tb_bakraid_cen_gate.sv
// Bench for bakraid_cen_gate: directed pause/step/abort/reset
// scenarios plus a random phase, all scored against a cycle model.
module tb_bakraid_cen_gate;

  localparam int N = 2;
  localparam int SW = 16;

  logic          CLK;
  logic          RESET;
  logic [N-1:0]  CEN_IN;
  logic [N-1:0]  CENB_IN;
  logic          PAUSE_REQ;
  logic          STEP_REQ;
  logic [SW-1:0] STEP_CNT;
  logic [N-1:0]  CEN_OUT;
  logic [N-1:0]  CENB_OUT;
  logic          PAUSED;
  logic          BUSY;

  bakraid_cen_gate #(.N(N), .STEPW(SW)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CEN_IN   (CEN_IN),
    .CENB_IN  (CENB_IN),
    .PAUSE_REQ(PAUSE_REQ),
    .STEP_REQ (STEP_REQ),
    .STEP_CNT (STEP_CNT),
    .CEN_OUT  (CEN_OUT),
    .CENB_OUT (CENB_OUT),
    .PAUSED   (PAUSED),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks;
  int fails;
  int t;
  bit rand_mode;

  // model: 0 run, 1 drain, 2 paused, 3 step
  int m_mode;
  bit m_open [N];
  bit m_owe  [N];
  int m_left;

  int oc [N];
  int ob [N];
  int busy_seen;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic clr_counts();
    for (int d = 0; d < N; d++) begin
      oc[d] = 0;
      ob[d] = 0;
    end
    busy_seen = 0;
  endtask

  task automatic drive_raw();
    if (rand_mode) begin
      for (int d = 0; d < N; d++) begin
        CEN_IN[d]  = ($urandom % 4) == 0;
        CENB_IN[d] = ($urandom % 4) == 0;
      end
    end else begin
      CEN_IN[0]  = (t % 7) == 0;
      CENB_IN[0] = (t % 7) == 3;
      CEN_IN[1]  = (t % 5) == 0;
      CENB_IN[1] = (t % 5) == 0;
    end
  endtask

  task automatic model_update();
    bit owe_n [N];
    bit any;
    if (RESET) begin
      m_mode = 0;
      m_left = 0;
      for (int d = 0; d < N; d++) begin
        m_open[d] = 1;
        m_owe[d]  = 0;
      end
      return;
    end
    for (int d = 0; d < N; d++)
      owe_n[d] = CENB_IN[d] ? 1'b0 : (CEN_IN[d] ? 1'b1 : m_owe[d]);
    case (m_mode)
      0: if (PAUSE_REQ) m_mode = 1;
      1: begin
        if (!PAUSE_REQ) begin
          m_mode = 0;
          for (int d = 0; d < N; d++) m_open[d] = 1;
        end else begin
          any = 0;
          for (int d = 0; d < N; d++) begin
            if (!owe_n[d]) m_open[d] = 0;
            if (m_open[d]) any = 1;
          end
          if (!any) m_mode = 2;
        end
      end
      2: begin
        if (!PAUSE_REQ) begin
          m_mode = 0;
          for (int d = 0; d < N; d++) m_open[d] = 1;
        end else if (STEP_REQ && STEP_CNT != 0) begin
          m_mode = 3;
          m_left = int'(STEP_CNT);
          for (int d = 0; d < N; d++) m_open[d] = 1;
        end
      end
      default: begin
        if (!PAUSE_REQ) begin
          m_mode = 0;
          m_left = 0;
        end else if (CEN_IN[0] && m_left > 0) begin
          m_left--;
          if (m_left == 0) m_mode = 1;
        end
      end
    endcase
    for (int d = 0; d < N; d++) m_owe[d] = owe_n[d];
  endtask

  task automatic tick();
    logic [N-1:0] e_cen;
    logic [N-1:0] e_cenb;
    drive_raw();
    @(negedge CLK);
    for (int d = 0; d < N; d++) begin
      e_cen[d]  = CEN_IN[d] && m_open[d];
      e_cenb[d] = CENB_IN[d] && m_open[d];
    end
    chk("cen_out", 32'(CEN_OUT), 32'(e_cen));
    chk("cenb_out", 32'(CENB_OUT), 32'(e_cenb));
    chk("paused", 32'(PAUSED), 32'(m_mode == 2));
    chk("busy", 32'(BUSY), 32'(m_mode == 1 || m_mode == 3));
    for (int d = 0; d < N; d++) begin
      oc[d] += int'(CEN_OUT[d]);
      ob[d] += int'(CENB_OUT[d]);
    end
    if (BUSY) busy_seen++;
    @(posedge CLK);
    model_update();
    #1;
    t++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic align(input int k);
    while ((t % 7) != k) tick();
  endtask

  task automatic wait_paused(input int bound, input string tag);
    int n;
    n = 0;
    while (m_mode != 2 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(PAUSED), 32'd1);
  endtask

  task automatic do_step(input int cnt);
    align(4);
    clr_counts();
    STEP_REQ = 1'b1;
    STEP_CNT = SW'(cnt);
    tick();
    STEP_REQ = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails = 0;
    t = 0;
    rand_mode = 0;
    RESET = 1'b1;
    PAUSE_REQ = 1'b0;
    STEP_REQ = 1'b0;
    STEP_CNT = '0;
    CEN_IN = '0;
    CENB_IN = '0;
    m_mode = 0;
    m_left = 0;
    for (int d = 0; d < N; d++) begin
      m_open[d] = 1;
      m_owe[d] = 0;
    end
    clr_counts();
    @(posedge CLK);
    #1;
    ticks(3);
    RESET = 1'b0;
    chk("reset_paused", 32'(PAUSED), 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);

    // pass-through
    align(4);
    clr_counts();
    ticks(200);
    chk("run_busy_seen", 32'(busy_seen), 32'd0);
    chk("run_cen0", 32'(oc[0]), 32'd29);
    chk("run_cen1", 32'(oc[1]), 32'd40);

    // balanced pause one clock after a domain-0 CEN
    align(1);
    PAUSE_REQ = 1'b1;
    wait_paused(8, "pause_reached");
    ticks(20);
    for (int d = 0; d < N; d++)
      chk("pause_balance", 32'(oc[d]), 32'(ob[d]));

    // step of 3
    do_step(3);
    wait_paused(60, "step3_done");
    ticks(10);
    chk("step3_cen", 32'(oc[0]), 32'd3);
    chk("step3_cenb", 32'(ob[0]), 32'd3);
    chk("step3_bal1", 32'(oc[1]), 32'(ob[1]));
    chk("step3_busy", 32'(busy_seen > 0), 32'd1);

    // step of 0 is ignored
    clr_counts();
    STEP_REQ = 1'b1;
    STEP_CNT = '0;
    tick();
    STEP_REQ = 1'b0;
    ticks(10);
    chk("step0_paused", 32'(PAUSED), 32'd1);
    chk("step0_cen", 32'(oc[0] + oc[1] + ob[0] + ob[1]), 32'd0);

    // STEP_REQ in RUN ignored
    PAUSE_REQ = 1'b0;
    ticks(3);
    STEP_REQ = 1'b1;
    STEP_CNT = SW'(4);
    tick();
    STEP_REQ = 1'b0;
    ticks(3);
    chk("runstep_busy", 32'(BUSY), 32'd0);
    chk("runstep_paused", 32'(PAUSED), 32'd0);

    // abort mid-drain
    align(1);
    PAUSE_REQ = 1'b1;
    ticks(2);
    chk("drain_busy", 32'(BUSY), 32'd1);
    PAUSE_REQ = 1'b0;
    tick();
    chk("abort_drain_busy", 32'(BUSY), 32'd0);
    ticks(10);

    // abort mid-step
    align(1);
    PAUSE_REQ = 1'b1;
    wait_paused(8, "pause2_reached");
    do_step(10);
    ticks(12);
    chk("midstep_busy", 32'(BUSY), 32'd1);
    PAUSE_REQ = 1'b0;
    tick();
    chk("abort_step_busy", 32'(BUSY), 32'd0);
    chk("abort_step_paused", 32'(PAUSED), 32'd0);
    ticks(10);

    // reset mid-step
    align(1);
    PAUSE_REQ = 1'b1;
    wait_paused(8, "pause3_reached");
    do_step(5);
    ticks(9);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    PAUSE_REQ = 1'b0;
    chk("rst_step_busy", 32'(BUSY), 32'd0);
    chk("rst_step_paused", 32'(PAUSED), 32'd0);
    ticks(10);
    align(1);
    PAUSE_REQ = 1'b1;
    wait_paused(8, "pause4_reached");
    do_step(1);
    wait_paused(40, "step1_done");
    ticks(10);
    chk("step1_cen", 32'(oc[0]), 32'd1);
    chk("step1_cenb", 32'(ob[0]), 32'd1);

    // random phase
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 16) == 0) PAUSE_REQ = ~PAUSE_REQ;
      STEP_REQ = ($urandom % 8) == 0;
      STEP_CNT = SW'($urandom_range(0, 3));
      RESET = ($urandom % 300) == 0;
      tick();
    end
    RESET = 1'b0;
    STEP_REQ = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
